// File: rtl/ps2_decoder.sv
// PS/2 keyboard receiver: synchronizes and deglitches the raw bus, frames
// 11-bit PS/2 words, and folds E0/F0/E1 prefix bytes into one key event.
module ps2_decoder #(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 50000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [10:0] ps2_key,
   output logic        err
);

   localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic          clk_s_p0, clk_s_p1;
   logic          data_s_p0, data_s_p1;
   logic [FW-1:0] flt_cnt;
   logic          clk_flt, clk_flt_d;
   logic          fall;

   state_t        state, state_nxt;
   logic [2:0]    bit_cnt, bit_cnt_nxt;
   logic [7:0]    shreg, shreg_nxt;
   logic          par_ok, par_ok_nxt;
   logic [TW-1:0] tmo_cnt, tmo_cnt_nxt;
   logic          byte_vld, frame_err;

   logic          ext_flag, brk_flag;
   logic [2:0]    pause_cnt;
   logic          key_stb;
   logic [9:0]    key_data;

   // Two-flop synchronizers; idle-high reset so release never fakes an edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_s_p0  <= 1'b1;
         clk_s_p1  <= 1'b1;
         data_s_p0 <= 1'b1;
         data_s_p1 <= 1'b1;
      end else begin
         clk_s_p0  <= ps2_clk;
         clk_s_p1  <= clk_s_p0;
         data_s_p0 <= ps2_data;
         data_s_p1 <= data_s_p0;
      end
   end

   // Glitch filter: flip only after FILTER_LEN consecutive differing samples
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flt_cnt   <= '0;
         clk_flt   <= 1'b1;
         clk_flt_d <= 1'b1;
      end else begin
         clk_flt_d <= clk_flt;
         if (clk_s_p1 == clk_flt) begin
            flt_cnt <= '0;
         end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
            clk_flt <= clk_s_p1;
            flt_cnt <= '0;
         end else begin
            flt_cnt <= flt_cnt + 1'b1;
         end
      end
   end

   assign fall = clk_flt_d & ~clk_flt;

   // Frame FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         bit_cnt <= '0;
         shreg   <= '0;
         par_ok  <= 1'b0;
         tmo_cnt <= '0;
      end else begin
         state   <= state_nxt;
         bit_cnt <= bit_cnt_nxt;
         shreg   <= shreg_nxt;
         par_ok  <= par_ok_nxt;
         tmo_cnt <= tmo_cnt_nxt;
      end
   end

   // Frame FSM next state: one bit per filtered falling edge, plus timeout abort
   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      shreg_nxt   = shreg;
      par_ok_nxt  = par_ok;
      tmo_cnt_nxt = tmo_cnt + 1'b1;
      byte_vld    = 1'b0;
      frame_err   = 1'b0;
      if (state == IDLE || fall) begin
         tmo_cnt_nxt = '0;
      end
      case (state)
         IDLE: begin
            if (fall) begin
               if (!data_s_p1) begin
                  state_nxt   = DATA;
                  bit_cnt_nxt = 3'd0;
               end else begin
                  frame_err = 1'b1;
               end
            end
         end
         DATA: begin
            if (fall) begin
               shreg_nxt   = {data_s_p1, shreg[7:1]};
               bit_cnt_nxt = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  state_nxt = PARITY;
               end
            end
         end
         PARITY: begin
            if (fall) begin
               // odd parity: data plus parity bit must hold an odd number of ones
               par_ok_nxt = ^{shreg, data_s_p1};
               state_nxt  = STOP;
            end
         end
         STOP: begin
            if (fall) begin
               state_nxt = IDLE;
               if (data_s_p1 && par_ok) begin
                  byte_vld = 1'b1;
               end else begin
                  frame_err = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (state != IDLE && !fall && tmo_cnt == TW'(TIMEOUT)) begin
         state_nxt   = IDLE;
         tmo_cnt_nxt = '0;
         frame_err   = 1'b1;
      end
   end

   // Prefix stage: fold E0/F0/E1 into flags and register the key event / error pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ext_flag  <= 1'b0;
         brk_flag  <= 1'b0;
         pause_cnt <= '0;
         key_stb   <= 1'b0;
         key_data  <= '0;
         err       <= 1'b0;
      end else begin
         key_stb <= 1'b0;
         err     <= frame_err;
         if (frame_err) begin
            ext_flag  <= 1'b0;
            brk_flag  <= 1'b0;
            pause_cnt <= '0;
         end else if (byte_vld) begin
            if (pause_cnt != 3'd0) begin
               // tail of the Pause sequence is swallowed whole
               pause_cnt <= pause_cnt - 3'd1;
            end else if (shreg == 8'hE0) begin
               ext_flag <= 1'b1;
            end else if (shreg == 8'hF0) begin
               brk_flag <= 1'b1;
            end else if (shreg == 8'hE1) begin
               pause_cnt <= 3'd7;
               ext_flag  <= 1'b0;
               brk_flag  <= 1'b0;
               key_stb   <= 1'b1;
               key_data  <= {1'b0, 1'b1, 8'h77};
            end else begin
               ext_flag <= 1'b0;
               brk_flag <= 1'b0;
               key_stb  <= 1'b1;
               key_data <= {brk_flag, ext_flag, shreg};
            end
         end
      end
   end

   assign ps2_key = {key_stb, key_data};

endmodule

// File: doc/ps2_decoder.md
PS2_DECODER -- requirements
Module: ps2_decoder

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive identical synchronized ps2_clk samples required before the filtered level changes.
REQ-002 Parameter TIMEOUT, default 50000: clk cycles without a filtered ps2_clk falling edge before an in-progress frame is aborted.
REQ-003 clk  input  1  system clock; all logic is in this single clock domain.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk.
REQ-006 ps2_data  input  1  raw PS/2 data line, asynchronous to clk.
REQ-007 ps2_key  output  11  key event: [10] strobe, [9] break, [8] extended (E0), [7:0] scancode.
REQ-008 err  output  1  one-cycle pulse on any parity, framing or timeout error.

Function
REQ-009 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before any other use.
REQ-010 The filtered clock SHALL change only after FILTER_LEN equal consecutive synchronized samples; a shorter glitch SHALL have no effect.
REQ-011 A bit SHALL be sampled from synchronized ps2_data on the cycle a filtered-clock falling edge is detected.
REQ-012 Frame FSM states: IDLE, DATA, PARITY, STOP.
REQ-013 IDLE: a sampled 0 SHALL go to DATA with bit count 0; a sampled 1 SHALL stay in IDLE, pulse err, and clear prefix state.
REQ-014 DATA: 8 bits SHALL be shifted in LSB first, then the FSM SHALL go to PARITY.
REQ-015 PARITY: the sampled bit SHALL make the total count of ones over data plus parity odd, else it is a parity error; the FSM SHALL go to STOP in either case.
REQ-016 STOP: a sampled 1 with good parity SHALL deliver the byte to the prefix stage; parity error or a sampled 0 SHALL pulse err, discard the byte and clear prefix state; the FSM SHALL return to IDLE.
REQ-017 Timeout counter: reset on each falling edge and in IDLE; on reaching TIMEOUT outside IDLE the FSM SHALL go to IDLE, pulse err and clear prefix state.
REQ-018 Prefix stage: byte E0 SHALL set ext_flag; byte F0 SHALL set brk_flag; neither emits an event.
REQ-019 Any other byte, with the pause counter at 0, SHALL emit ps2_key = {1, brk_flag, ext_flag, byte} and clear both flags.
REQ-020 Byte E1, with the pause counter at 0, SHALL load the pause counter with 7, clear both flags, and emit {1,0,1,8'h77} on the same cycle.
REQ-021 While the pause counter is nonzero, each delivered byte SHALL decrement it and be discarded, including E0, F0 and E1.
REQ-022 ps2_key[10] SHALL be high for exactly one clk cycle per event, starting the cycle after the STOP bit is sampled.
REQ-023 ps2_key[9:0] SHALL hold its value until the next event.
REQ-024 err and the ps2_key[10] strobe SHALL never be asserted in the same cycle.
REQ-025 Back-to-back frames with no idle gap beyond the stop bit SHALL all be decoded.

Reset
REQ-026 On reset_n low the block SHALL immediately clear: ps2_key=11'h000, err=0, FSM=IDLE, flags=0, pause counter=0, timeout counter=0, shift register=0.
REQ-027 Synchronizer and filter state SHALL reset to 1 (idle-high bus), so no falling edge is detected on release of reset_n.
REQ-028 Assertion of reset_n mid-frame SHALL abort the frame, with no event and no err pulse after release.

Verification
REQ-029 Frame 1C with parity 0 -> one strobe, ps2_key=11'h41C.
REQ-030 Frames F0, 1C -> single strobe, ps2_key=11'h61C; E0, F0, 75 -> single strobe, ps2_key=11'h775.
REQ-031 Frame 1C with parity bit inverted -> err pulse, no strobe; a following good 1C -> 11'h41C with no stale flags.
REQ-032 Sequence E1 14 77 E1 F0 14 F0 77, then 1C -> strobe 11'h577 at the first byte, next strobe 11'h41C.
REQ-033 Frame stopped after 4 data bits for TIMEOUT+1 cycles -> err pulse, FSM IDLE; the next good frame decodes correctly.
REQ-034 ps2_clk glitches of FILTER_LEN-1 cycles injected during a 1C frame -> decoded 11'h41C unchanged; reset_n pulsed mid-frame -> outputs 0, no event.
